// File: rtl/candy_id_if.sv
// candy_id_if: IF/ID handshake, register-file read, EX write-back and ID/EX output bundle for candy_id
interface candy_id_if;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluop;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_wd;
  logic        out_wreg;
  logic        out_illegal;
  modport slave (
    input  in_valid, in_inst, rdata1, rdata2, ex_we, ex_waddr, ex_wdata, flush, out_ready,
    output in_ready, re1, re2, raddr1, raddr2, out_valid, out_aluop, out_op1, out_op2,
           out_wd, out_wreg, out_illegal
  );
  modport master (
    output in_valid, in_inst, rdata1, rdata2, ex_we, ex_waddr, ex_wdata, flush, out_ready,
    input  in_ready, re1, re2, raddr1, raddr2, out_valid, out_aluop, out_op1, out_op2,
           out_wd, out_wreg, out_illegal
  );
endinterface

// File: rtl/candy_id.sv
// candy_id: MIPS-subset decode stage with one-cycle ID/EX register; CANDY_ID_FWD_EN enables EX-to-ID bypass
module candy_id (
  input logic      clk,
  input logic      rst,
  candy_id_if.slave bus
);
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sh, wd;
  logic [15:0] imm;
  logic        is_r, is_sll, r_alu, is_ori, is_addiu, is_lui, legal, use_rs, use_rt;
  logic        byp1, byp2, hazard, accept, wreg;
  logic [3:0]  aluop;
  logic [31:0] src1, src2, op1, op2;
  assign op       = bus.in_inst[31:26];
  assign rs       = bus.in_inst[25:21];
  assign rt       = bus.in_inst[20:16];
  assign rd       = bus.in_inst[15:11];
  assign sh       = bus.in_inst[10:6];
  assign funct    = bus.in_inst[5:0];
  assign imm      = bus.in_inst[15:0];
  assign is_r     = op == 6'b000000;
  assign is_sll   = is_r && funct == 6'b000000;
  assign r_alu    = is_r && (funct inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110});
  assign is_ori   = op == 6'b001101;
  assign is_addiu = op == 6'b001001;
  assign is_lui   = op == 6'b001111;
  assign legal    = is_sll || r_alu || is_ori || is_addiu || is_lui;
  assign use_rs   = r_alu || is_ori || is_addiu;
  assign use_rt   = r_alu || is_sll;
  assign bus.re1    = bus.in_valid && use_rs;
  assign bus.re2    = bus.in_valid && use_rt;
  assign bus.raddr1 = bus.re1 ? rs : 5'd0;
  assign bus.raddr2 = bus.re2 ? rt : 5'd0;
`ifdef CANDY_ID_FWD_EN
  assign byp1   = bus.ex_we && bus.ex_waddr == bus.raddr1;
  assign byp2   = bus.ex_we && bus.ex_waddr == bus.raddr2;
  assign hazard = 1'b0;
`else
  assign byp1   = 1'b0;
  assign byp2   = 1'b0;
  assign hazard = bus.ex_we && bus.ex_waddr != 5'd0 &&
                  ((bus.re1 && bus.ex_waddr == bus.raddr1) || (bus.re2 && bus.ex_waddr == bus.raddr2));
`endif
  // disabled reads force raddr to 0, so register 0 covers both "unused" and "$zero"
  assign src1 = bus.raddr1 == 5'd0 ? 32'd0 : byp1 ? bus.ex_wdata : bus.rdata1;
  assign src2 = bus.raddr2 == 5'd0 ? 32'd0 : byp2 ? bus.ex_wdata : bus.rdata2;
  always_comb begin
    aluop = is_ori ? 4'd4 : is_addiu ? 4'd1 : is_lui ? 4'd7 : is_sll ? 4'd6 : !r_alu ? 4'd0 :
            funct == 6'b100001 ? 4'd1 : funct == 6'b100011 ? 4'd2 :
            funct == 6'b100100 ? 4'd3 : funct == 6'b100101 ? 4'd4 : 4'd5;
    wd    = use_rt ? rd : (is_ori || is_addiu || is_lui) ? rt : 5'd0;
    wreg  = legal && wd != 5'd0;
    op1   = is_sll ? {27'd0, sh} : src1;
    op2   = use_rt ? src2 : is_ori ? {16'd0, imm} : is_addiu ? {{16{imm[15]}}, imm} :
            is_lui ? {imm, 16'd0} : 32'd0;
  end
  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_aluop   <= 4'd0;
      bus.out_op1     <= 32'd0;
      bus.out_op2     <= 32'd0;
      bus.out_wd      <= 5'd0;
      bus.out_wreg    <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.out_aluop   <= aluop;
      bus.out_op1     <= op1;
      bus.out_op2     <= op2;
      bus.out_wd      <= wd;
      bus.out_wreg    <= wreg;
      bus.out_illegal <= !legal;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_candy_id.sv
// tb_candy_id: directed vectors for candy_id, expected values hand-computed from the MIPS encodings
module tb_candy_id;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic [31:0] regs [32];
  localparam logic [31:0] ORI   = 32'h342200FF;
  localparam logic [31:0] ADDIU = 32'h2403FFFF;
  localparam logic [31:0] LUI   = 32'h3C04ABCD;
  localparam logic [31:0] ADDU  = 32'h00C72821;
  localparam logic [31:0] SLL   = 32'h000740C0;
  localparam logic [31:0] XORZ  = 32'h00074826;
  localparam logic [31:0] BAD   = 32'hFC000000;
  candy_id_if bus ();
  candy_id u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.rdata1 = regs[bus.raddr1];
  assign bus.rdata2 = regs[bus.raddr2];
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    foreach (regs[i]) regs[i] = 32'h0;
    regs[0] = 32'hFFFFFFFF;
    regs[1] = 32'h12340000;
    regs[6] = 32'h00000066;
    regs[7] = 32'h00000077;
    bus.in_valid = 1'b0; bus.in_inst = 32'h0; bus.ex_we = 1'b0; bus.ex_waddr = 5'd0;
    bus.ex_wdata = 32'h0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    #12;
    check("rst_valid", bus.out_valid, 0);
    check("rst_aluop", bus.out_aluop, 0);
    check("rst_op1", bus.out_op1, 0);
    check("rst_wreg", bus.out_wreg, 0);
    check("idle_re1", bus.re1, 0);
    step();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_inst = ORI;
    #1;
    check("ori_re1", bus.re1, 1);
    check("ori_raddr1", bus.raddr1, 1);
    check("ori_re2", bus.re2, 0);
    check("ori_raddr2", bus.raddr2, 0);
    check("ori_rdy", bus.in_ready, 1);
    step();
    check("ori_valid", bus.out_valid, 1);
    check("ori_aluop", bus.out_aluop, 4);
    check("ori_op1", bus.out_op1, 32'h12340000);
    check("ori_op2", bus.out_op2, 32'h000000FF);
    check("ori_wd", bus.out_wd, 2);
    check("ori_wreg", bus.out_wreg, 1);
    bus.in_inst = ADDIU;
    step();
    check("addiu_aluop", bus.out_aluop, 1);
    check("addiu_op1", bus.out_op1, 0);
    check("addiu_op2", bus.out_op2, 32'hFFFFFFFF);
    check("addiu_wd", bus.out_wd, 3);
    bus.in_inst = LUI;
    #1;
    check("lui_re1", bus.re1, 0);
    check("lui_raddr1", bus.raddr1, 0);
    step();
    check("lui_aluop", bus.out_aluop, 7);
    check("lui_op1", bus.out_op1, 0);
    check("lui_op2", bus.out_op2, 32'hABCD0000);
    check("lui_wd", bus.out_wd, 4);
    bus.in_inst = ADDU;
    step();
    check("addu_aluop", bus.out_aluop, 1);
    check("addu_op1", bus.out_op1, 32'h66);
    check("addu_op2", bus.out_op2, 32'h77);
    check("addu_wd", bus.out_wd, 5);
    bus.out_ready = 1'b0; bus.in_inst = SLL;
    #1;
    check("stall_rdy", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", bus.out_valid, 1);
      check("stall_op1", bus.out_op1, 32'h66);
      check("stall_wd", bus.out_wd, 5);
      check("stall_aluop", bus.out_aluop, 1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("resume_rdy", bus.in_ready, 1);
    step();
    check("sll_valid", bus.out_valid, 1);
    check("sll_aluop", bus.out_aluop, 6);
    check("sll_op1", bus.out_op1, 3);
    check("sll_op2", bus.out_op2, 32'h77);
    check("sll_wd", bus.out_wd, 8);
    bus.in_inst = XORZ;
    step();
    check("xor_aluop", bus.out_aluop, 5);
    check("xor_op1_r0", bus.out_op1, 0);
    check("xor_op2", bus.out_op2, 32'h77);
    bus.in_inst = ADDU; bus.ex_we = 1'b1; bus.ex_waddr = 5'd6; bus.ex_wdata = 32'hDEADBEEF;
    #1;
`ifdef CANDY_ID_FWD_EN
    check("fwd_rdy", bus.in_ready, 1);
    step();
    check("fwd_op1", bus.out_op1, 32'hDEADBEEF);
    check("fwd_op2", bus.out_op2, 32'h77);
`else
    check("haz_rdy", bus.in_ready, 0);
    step();
    check("haz_drain", bus.out_valid, 0);
    check("haz_rdy2", bus.in_ready, 0);
    bus.ex_we = 1'b0;
    #1;
    check("haz_clear", bus.in_ready, 1);
    step();
    check("haz_valid", bus.out_valid, 1);
    check("haz_op1", bus.out_op1, 32'h66);
`endif
    bus.ex_we = 1'b0;
    bus.in_inst = BAD;
    step();
    check("bad_valid", bus.out_valid, 1);
    check("bad_illegal", bus.out_illegal, 1);
    check("bad_wreg", bus.out_wreg, 0);
    check("bad_aluop", bus.out_aluop, 0);
    bus.in_inst = ORI; bus.flush = 1'b1;
    step();
    check("flush_valid", bus.out_valid, 0);
    bus.flush = 1'b0; bus.in_inst = 32'h0;
    step();
    check("nop_valid", bus.out_valid, 1);
    check("nop_aluop", bus.out_aluop, 6);
    check("nop_wreg", bus.out_wreg, 0);
    check("nop_illegal", bus.out_illegal, 0);
    bus.in_inst = ADDU;
    step();
    bus.out_ready = 1'b0; bus.in_inst = ORI;
    step();
    check("pre_rst_rdy", bus.in_ready, 0);
    check("pre_rst_valid", bus.out_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("async_valid", bus.out_valid, 0);
    check("async_aluop", bus.out_aluop, 0);
    check("async_op1", bus.out_op1, 0);
    check("async_wd", bus.out_wd, 0);
    @(negedge clk);
    rst = 1'b1; bus.out_ready = 1'b1;
    #1;
    check("post_rst_rdy", bus.in_ready, 1);
    step();
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_aluop", bus.out_aluop, 4);
    check("post_rst_op1", bus.out_op1, 32'h12340000);
    bus.in_valid = 1'b0;
    step();
    check("drain_valid", bus.out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
